// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encoding and BCD digit constants
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;
  localparam int DW = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [4:0] BCD_RADIX = 5'd10;
endpackage

// File: rtl/bcd_digit_sub.sv
// bcd_digit_sub: one BCD digit of x - y - bin with decimal borrow
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);
  logic [4:0] t;
  logic [4:0] f;
  // a negative raw difference shows up as bit 4 set; adding the radix folds it back into 0..9
  always_comb begin
    t = {1'b0, x} - {1'b0, y} - {4'd0, bin};
    f = t + BCD_RADIX;
    bout = t[4];
    d = t[4] ? f[3:0] : t[3:0];
  end
endmodule

// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor: digit-serial BCD subtractor; define BCD_SUB_SIGN_MAG_EN for sign-magnitude results
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic              Bin,
  output logic [4*NDIG-1:0] diff,
  output logic              Bout,
  output logic              neg,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int W = DW * NDIG;
  localparam int IW = $clog2(NDIG + 1);
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);
  state_t state;
  logic [W-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic borrow, bad, bo;
  logic [3:0] x, y, d;
`ifdef BCD_SUB_SIGN_MAG_EN
  logic neg_r;
  assign neg = neg_r;
`else
  assign neg = 1'b0;
`endif
  // flag any operand digit outside 0..9 at the moment of capture
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++)
      bad = bad | (a[i*DW +: DW] > BCD_MAX) | (b[i*DW +: DW] > BCD_MAX);
  end
  // FIX reuses the digit subtractor to negate the stored tens-complement result
  always_comb begin
`ifdef BCD_SUB_SIGN_MAG_EN
    x = (state == FIX) ? 4'd0 : a_r[idx*DW +: DW];
    y = (state == FIX) ? diff[idx*DW +: DW] : b_r[idx*DW +: DW];
`else
    x = a_r[idx*DW +: DW];
    y = b_r[idx*DW +: DW];
`endif
  end
  bcd_digit_sub u_dig (.x(x), .y(y), .bin(borrow), .d(d), .bout(bo));
  // control FSM with registered outputs; done is raised on entry to DONE and dropped leaving it
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      idx <= '0;
      borrow <= 1'b0;
      diff <= '0;
      Bout <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
`ifdef BCD_SUB_SIGN_MAG_EN
      neg_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r <= a;
          b_r <= b;
          borrow <= Bin;
          idx <= '0;
          diff <= '0;
          Bout <= 1'b0;
          err <= bad;
          busy <= !bad;
          done <= bad;
          state <= bad ? DONE : SUB;
`ifdef BCD_SUB_SIGN_MAG_EN
          neg_r <= 1'b0;
`endif
        end
        SUB: begin
          diff[idx*DW +: DW] <= d;
          borrow <= bo;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            Bout <= bo;
`ifdef BCD_SUB_SIGN_MAG_EN
            if (bo) begin
              neg_r <= 1'b1;
              idx <= '0;
              borrow <= 1'b0;
              state <= FIX;
            end else begin
              busy <= 1'b0;
              done <= 1'b1;
              state <= DONE;
            end
`else
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
`endif
          end
        end
`ifdef BCD_SUB_SIGN_MAG_EN
        FIX: begin
          diff[idx*DW +: DW] <= d;
          borrow <= bo;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end
        end
`endif
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
